// File: rtl/fifo_burst_reader_pkg.sv
// Shared types for fifo_burst_reader: FSM state encoding, byte-select constants and
// the word-to-byte selection helper used by the unpacker.
package fifo_burst_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND0   = 3'd3,
    ST_SEND1   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic SEL_FIRST  = 1'b0;
  localparam logic SEL_SECOND = 1'b1;

  // Returns the byte of word sent in phase sel, honouring the byte order.
  function automatic logic [7:0] pick_byte(input logic [15:0] word,
                                           input logic        lsb_first,
                                           input logic        sel);
    logic take_high;
    take_high = sel ^ ~lsb_first;
    if (take_high) begin
      return word[15:8];
    end else begin
      return word[7:0];
    end
  endfunction

endpackage

// File: rtl/fifo_burst_reader_unpacker.sv
// fifo_word_unpacker: selects the first or second byte of a captured 16-bit word.
module fifo_word_unpacker
  import fifo_burst_reader_pkg::*;
#(
  parameter int pLSB_FIRST = 1
) (
  input  logic [15:0] word,
  input  logic        byte_sel,
  output logic [7:0]  byte_out
);

  localparam logic LSB_FIRST = (pLSB_FIRST != 0);

  always_comb begin
    byte_out = pick_byte(word, LSB_FIRST, byte_sel);
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains burst_len words from a non-FWFT fifo_sync and emits them as a
// valid/ready byte stream. Build macro FIFO_BURST_READER_STATS_EN enables the words_total counter.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int pDATA_WIDTH  = 16,
  parameter int pBURST_WIDTH = 16,
  parameter int pLSB_FIRST   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [pBURST_WIDTH-1:0] burst_len,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic                    fifo_ren,
  input  logic [pDATA_WIDTH-1:0]  fifo_rdata,
  input  logic                    fifo_empty,
  input  logic                    fifo_underflow,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [31:0]             words_total
);

  localparam logic [pBURST_WIDTH-1:0] REM_ZERO = {pBURST_WIDTH{1'b0}};
  localparam logic [pBURST_WIDTH-1:0] REM_ONE  = {{(pBURST_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [pDATA_WIDTH-1:0]  word_q, word_d;
  logic [pBURST_WIDTH-1:0] rem_q, rem_d;
  logic                    error_q, error_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic [7:0]              out_data_q, out_data_d;
  logic [7:0]              next_byte;
  logic                    sel_d;

  // Outputs are registered from the next state so they line up with state_q.
  assign sel_d = (state_d == ST_SEND1) ? SEL_SECOND : SEL_FIRST;

  fifo_word_unpacker #(
    .pLSB_FIRST (pLSB_FIRST)
  ) u_unpacker (
    .word     (word_d),
    .byte_sel (sel_d),
    .byte_out (next_byte)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      word_q      <= {pDATA_WIDTH{1'b0}};
      rem_q       <= REM_ZERO;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      rem_q       <= rem_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    rem_d   = rem_q;
    if (busy_q && fifo_underflow) begin
      error_d = 1'b1;
    end else begin
      error_d = error_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d   = burst_len;
          error_d = 1'b0;
          if (burst_len != REM_ZERO) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (!fifo_empty) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_CAPTURE: begin
        word_d  = fifo_rdata;
        rem_d   = rem_q - REM_ONE;
        state_d = ST_SEND0;
      end
      ST_SEND0: begin
        if (out_ready) begin
          state_d = ST_SEND1;
        end else begin
          state_d = ST_SEND0;
        end
      end
      ST_SEND1: begin
        if (out_ready) begin
          state_d = (rem_q != REM_ZERO) ? ST_READ : ST_DONE;
        end else begin
          state_d = ST_SEND1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode; fifo_ren is the only combinational output
  always_comb begin
    fifo_ren    = (state_q == ST_READ) && !fifo_empty;
    busy_d      = (state_d inside {ST_READ, ST_CAPTURE, ST_SEND0, ST_SEND1});
    done_d      = (state_d == ST_DONE);
    out_valid_d = (state_d == ST_SEND0) || (state_d == ST_SEND1);
    out_last_d  = (state_d == ST_SEND1) && (rem_d == REM_ZERO);
    if (out_valid_d) begin
      out_data_d = next_byte;
    end else begin
      out_data_d = out_data_q;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

`ifdef FIFO_BURST_READER_STATS_EN
  logic [31:0] words_total_q, words_total_d;

  // Saturating count of captured words, cleared only by reset
  always_comb begin
    if ((state_q == ST_CAPTURE) && (words_total_q != 32'hFFFF_FFFF)) begin
      words_total_d = words_total_q + 32'd1;
    end else begin
      words_total_d = words_total_q;
    end
  end

  // Statistics register
  always_ff @(posedge clk) begin
    if (reset) begin
      words_total_q <= 32'd0;
    end else begin
      words_total_q <= words_total_d;
    end
  end

  assign words_total = words_total_q;
`else
  assign words_total = 32'd0;
`endif

endmodule
